// File: rtl/gp_trig_regfile.sv
// Trigger-config register file: bus-written staging copies, atomically committed active copies.
// Optional per-byte write strobes are enabled by defining GP_TRIG_REGFILE_WSTRB_EN.
module gp_trig_regfile #(
  parameter int DATA_WIDTH       = 32,
  parameter int TRANS_ADDR_WIDTH = 8,
  parameter int NUM_TRIG         = 8
) (
  input  logic                           i_clk,
  input  logic                           i_rst,
  input  logic                           slv_o_valid,
  input  logic                           slv_o_rd0_wr1,
  input  logic [DATA_WIDTH-1:0]          slv_o_wr_data,
`ifdef GP_TRIG_REGFILE_WSTRB_EN
  input  logic [DATA_WIDTH/8-1:0]        slv_o_wr_strb,
`endif
  input  logic [TRANS_ADDR_WIDTH-1:0]    trans_addr,
  input  logic                           reg_en,
  output logic                           slv_i_ready,
  output logic [DATA_WIDTH-1:0]          slv_i_rd_data,
  output logic                           slv_i_rd_valid,
  input  logic                           reg_rd_en,
  output logic [NUM_TRIG*DATA_WIDTH-1:0] rd_trig_config,
  output logic                           reg_rd_valid,
  output logic                           commit_done
);

  localparam int NB    = DATA_WIDTH / 8;
  localparam int IDX_W = (NUM_TRIG > 1) ? $clog2(NUM_TRIG) : 1;
  localparam logic [TRANS_ADDR_WIDTH-1:0] STAGE_END = TRANS_ADDR_WIDTH'(NUM_TRIG);
  localparam logic [TRANS_ADDR_WIDTH-1:0] CTRL_ADDR = TRANS_ADDR_WIDTH'(NUM_TRIG);
  localparam logic [TRANS_ADDR_WIDTH-1:0] STAT_ADDR = TRANS_ADDR_WIDTH'(NUM_TRIG + 1);

  typedef enum logic {ST_IDLE, ST_RESP} bus_state_e;

  logic [DATA_WIDTH-1:0] staging_q [NUM_TRIG];
  logic [DATA_WIDTH-1:0] staging_d [NUM_TRIG];
  logic [DATA_WIDTH-1:0] active_q  [NUM_TRIG];

  logic lock_q, lock_d;
  logic pending_q, pending_d;
  logic wr_err_q, wr_err_d;
  logic commit_done_q, reg_rd_valid_q;

  bus_state_e            state_q;
  logic                  ready_q, rd_valid_q;
  logic [DATA_WIDTH-1:0] rd_data_q;
  logic [DATA_WIDTH-1:0] rd_mux;

  logic [NB-1:0]         wr_strb;
  logic [DATA_WIDTH-1:0] wr_mask;
  logic                  accept, wr_acc, rd_acc, wr_any, commit_fire;
  logic                  addr_stage, addr_ctrl, addr_stat;
  logic [IDX_W-1:0]      idx;

`ifdef GP_TRIG_REGFILE_WSTRB_EN
  assign wr_strb = slv_o_wr_strb;
`else
  assign wr_strb = '1;
`endif

  always_comb begin
    wr_mask = '0;
    for (int b = 0; b < NB; b++) begin
      wr_mask[b*8 +: 8] = {8{wr_strb[b]}};
    end
  end

  assign accept      = reg_en & slv_o_valid & ready_q;
  assign wr_acc      = accept & slv_o_rd0_wr1;
  assign rd_acc      = accept & ~slv_o_rd0_wr1;
  assign wr_any      = |wr_strb;
  assign addr_stage  = (trans_addr < STAGE_END);
  assign addr_ctrl   = (trans_addr == CTRL_ADDR);
  assign addr_stat   = (trans_addr == STAT_ADDR);
  assign idx         = trans_addr[IDX_W-1:0];
  // Commit waits for a cycle where the trigger FSM is not sampling the active copies.
  assign commit_fire = pending_q & ~reg_rd_en;

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    staging_d = staging_q;
    lock_d    = lock_q;
    pending_d = pending_q;
    wr_err_d  = wr_err_q;
    if (commit_fire) pending_d = 1'b0;
    if (wr_acc && wr_any) begin
      if (addr_stage) begin
        if (lock_q) wr_err_d = 1'b1;
        else staging_d[idx] = (staging_q[idx] & ~wr_mask) | (slv_o_wr_data & wr_mask);
      end else if (addr_ctrl) begin
        if (wr_strb[0]) begin
          lock_d = slv_o_wr_data[0];
          if (slv_o_wr_data[1]) pending_d = 1'b1;
          if (slv_o_wr_data[2]) wr_err_d  = 1'b0;
        end
      end else if (!addr_stat) begin
        wr_err_d = 1'b1;
      end
    end
  end

  always_comb begin
    rd_mux = '0;
    if (addr_stage)     rd_mux = staging_q[idx];
    else if (addr_ctrl) rd_mux = {{(DATA_WIDTH-1){1'b0}}, lock_q};
    else if (addr_stat) rd_mux = {{(DATA_WIDTH-2){1'b0}}, wr_err_q, pending_q};
  end

  // NOTE: the register arrays are reset explicitly; a reset must discard staged and active state.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      for (int k = 0; k < NUM_TRIG; k++) begin
        staging_q[k] <= '0;
        active_q[k]  <= '0;
      end
      lock_q         <= 1'b0;
      pending_q      <= 1'b0;
      wr_err_q       <= 1'b0;
      commit_done_q  <= 1'b0;
      reg_rd_valid_q <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments let active load the pre-edge staging values.
      staging_q      <= staging_d;
      lock_q         <= lock_d;
      pending_q      <= pending_d;
      wr_err_q       <= wr_err_d;
      commit_done_q  <= commit_fire;
      reg_rd_valid_q <= reg_rd_en;
      if (commit_fire) begin
        for (int k = 0; k < NUM_TRIG; k++) active_q[k] <= staging_q[k];
      end
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q    <= ST_IDLE;
      ready_q    <= 1'b1;
      rd_valid_q <= 1'b0;
      rd_data_q  <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (rd_acc) begin
            state_q    <= ST_RESP;
            ready_q    <= 1'b0;
            rd_valid_q <= 1'b1;
            rd_data_q  <= rd_mux;
          end
        end
        ST_RESP: begin
          state_q    <= ST_IDLE;
          ready_q    <= 1'b1;
          rd_valid_q <= 1'b0;
        end
      endcase
    end
  end

  for (genvar k = 0; k < NUM_TRIG; k++) begin : g_flat
    assign rd_trig_config[k*DATA_WIDTH +: DATA_WIDTH] = active_q[k];
  end

  assign slv_i_ready    = ready_q;
  assign slv_i_rd_valid = rd_valid_q;
  assign slv_i_rd_data  = rd_data_q;
  assign reg_rd_valid   = reg_rd_valid_q;
  assign commit_done    = commit_done_q;

endmodule

// File: tb/tb_gp_trig_regfile.sv
// Directed bench for gp_trig_regfile: table-driven bus vectors plus hand-written commit/lock/reset sequences.
module tb_gp_trig_regfile;

  localparam int DW = 32;
  localparam int AW = 8;
  localparam int NT = 8;

  typedef struct {
    logic        en;
    logic        wr;
    logic [7:0]  addr;
    logic [31:0] data;
    logic [31:0] exp;
  } vec_t;

  logic             i_clk = 1'b0;
  logic             i_rst = 1'b1;
  logic             slv_o_valid = 1'b0;
  logic             slv_o_rd0_wr1 = 1'b0;
  logic [DW-1:0]    slv_o_wr_data = '0;
  logic [AW-1:0]    trans_addr = '0;
  logic             reg_en = 1'b1;
  logic             reg_rd_en = 1'b0;
  logic             slv_i_ready;
  logic [DW-1:0]    slv_i_rd_data;
  logic             slv_i_rd_valid;
  logic [NT*DW-1:0] rd_trig_config;
  logic             reg_rd_valid;
  logic             commit_done;
`ifdef GP_TRIG_REGFILE_WSTRB_EN
  logic [DW/8-1:0]  slv_o_wr_strb = '1;
`endif

  int n_checks = 0;
  int n_pass   = 0;

  gp_trig_regfile #(.DATA_WIDTH(DW), .TRANS_ADDR_WIDTH(AW), .NUM_TRIG(NT)) dut (
    .i_clk          (i_clk),
    .i_rst          (i_rst),
    .slv_o_valid    (slv_o_valid),
    .slv_o_rd0_wr1  (slv_o_rd0_wr1),
    .slv_o_wr_data  (slv_o_wr_data),
`ifdef GP_TRIG_REGFILE_WSTRB_EN
    .slv_o_wr_strb  (slv_o_wr_strb),
`endif
    .trans_addr     (trans_addr),
    .reg_en         (reg_en),
    .slv_i_ready    (slv_i_ready),
    .slv_i_rd_data  (slv_i_rd_data),
    .slv_i_rd_valid (slv_i_rd_valid),
    .reg_rd_en      (reg_rd_en),
    .rd_trig_config (rd_trig_config),
    .reg_rd_valid   (reg_rd_valid),
    .commit_done    (commit_done)
  );

  always #5 i_clk = ~i_clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
  endtask

  function automatic logic [31:0] entry(input int k);
    return rd_trig_config[k*DW +: DW];
  endfunction

  // Called at a negedge; returns at the negedge after the accept edge.
  task automatic bus_write(input logic [7:0] addr, input logic [31:0] data);
    slv_o_valid   = 1'b1;
    slv_o_rd0_wr1 = 1'b1;
    trans_addr    = addr;
    slv_o_wr_data = data;
    @(negedge i_clk);
    slv_o_valid   = 1'b0;
    slv_o_rd0_wr1 = 1'b0;
  endtask

  task automatic bus_read(input logic [7:0] addr, input logic [31:0] exp);
    slv_o_valid   = 1'b1;
    slv_o_rd0_wr1 = 1'b0;
    trans_addr    = addr;
    @(negedge i_clk);
    slv_o_valid = 1'b0;
    check($sformatf("rd_valid_a%0d", addr), 32'(slv_i_rd_valid), 32'd1);
    check($sformatf("ready_resp_a%0d", addr), 32'(slv_i_ready), 32'd0);
    check($sformatf("rd_data_a%0d", addr), slv_i_rd_data, exp);
    @(negedge i_clk);
    check($sformatf("rd_valid_off_a%0d", addr), 32'(slv_i_rd_valid), 32'd0);
  endtask

  task automatic apply_vec(input vec_t v);
    reg_en = v.en;
    if (v.wr) bus_write(v.addr, v.data);
    else      bus_read(v.addr, v.exp);
    reg_en = 1'b1;
  endtask

  vec_t vec_a [8];
  vec_t vec_b [11];

  initial begin
    vec_a[0] = '{1'b1, 1'b1, 8'd2,  32'hDEAD_BEEF, 32'h0};
    vec_a[1] = '{1'b1, 1'b0, 8'd2,  32'h0,         32'hDEAD_BEEF};
    vec_a[2] = '{1'b0, 1'b1, 8'd2,  32'h0BAD_0BAD, 32'h0};
    vec_a[3] = '{1'b1, 1'b0, 8'd2,  32'h0,         32'hDEAD_BEEF};
    vec_a[4] = '{1'b1, 1'b1, 8'd5,  32'h0000_0055, 32'h0};
    vec_a[5] = '{1'b1, 1'b0, 8'd5,  32'h0,         32'h0000_0055};
    vec_a[6] = '{1'b1, 1'b0, 8'd8,  32'h0,         32'h0};
    vec_a[7] = '{1'b1, 1'b0, 8'd9,  32'h0,         32'h0};

    vec_b[0]  = '{1'b1, 1'b1, 8'd8,  32'h1,         32'h0};
    vec_b[1]  = '{1'b1, 1'b1, 8'd0,  32'h1234_5678, 32'h0};
    vec_b[2]  = '{1'b1, 1'b1, 8'd13, 32'h99,        32'h0};
    vec_b[3]  = '{1'b1, 1'b0, 8'd0,  32'h0,         32'hA000_0000};
    vec_b[4]  = '{1'b1, 1'b0, 8'd9,  32'h0,         32'h2};
    vec_b[5]  = '{1'b1, 1'b0, 8'd13, 32'h0,         32'h0};
    vec_b[6]  = '{1'b1, 1'b0, 8'd8,  32'h0,         32'h1};
    vec_b[7]  = '{1'b1, 1'b1, 8'd8,  32'h4,         32'h0};
    vec_b[8]  = '{1'b1, 1'b0, 8'd9,  32'h0,         32'h0};
    vec_b[9]  = '{1'b1, 1'b1, 8'd0,  32'h1234_5678, 32'h0};
    vec_b[10] = '{1'b1, 1'b0, 8'd0,  32'h0,         32'h1234_5678};

    // Reset state
    repeat (2) @(negedge i_clk);
    i_rst = 1'b0;
    check("rst_ready", 32'(slv_i_ready), 32'd1);
    check("rst_rd_valid", 32'(slv_i_rd_valid), 32'd0);
    check("rst_rd_data", slv_i_rd_data, 32'h0);
    check("rst_cfg_zero", 32'(|rd_trig_config), 32'd0);

    // Reset asserted in the middle of a read response
    reg_rd_en = 1'b1;
    bus_write(8'd0, 32'h1111_1111);
    check("reg_rd_valid_follow", 32'(reg_rd_valid), 32'd1);
    slv_o_valid = 1'b1;
    trans_addr  = 8'd0;
    @(negedge i_clk);
    check("midread_valid", 32'(slv_i_rd_valid), 32'd1);
    check("midread_data", slv_i_rd_data, 32'h1111_1111);
    slv_o_valid = 1'b0;
    i_rst = 1'b1;
    #1;
    check("rst2_ready", 32'(slv_i_ready), 32'd1);
    check("rst2_rd_valid", 32'(slv_i_rd_valid), 32'd0);
    check("rst2_rd_data", slv_i_rd_data, 32'h0);
    check("rst2_reg_rd_valid", 32'(reg_rd_valid), 32'd0);
    check("rst2_commit_done", 32'(commit_done), 32'd0);
    check("rst2_cfg_zero", 32'(|rd_trig_config), 32'd0);
    @(negedge i_clk);
    i_rst = 1'b0;
    reg_rd_en = 1'b0;
    bus_read(8'd0, 32'h0);
    bus_read(8'd9, 32'h0);

    // Basic write/readback vectors
    for (int i = 0; i < 8; i++) apply_vec(vec_a[i]);
    check("cfg2_uncommitted", entry(2), 32'h0);

    // Back-to-back writes then an immediate commit
    for (int k = 0; k < NT; k++) begin
      slv_o_valid   = 1'b1;
      slv_o_rd0_wr1 = 1'b1;
      trans_addr    = 8'(k);
      slv_o_wr_data = 32'hA000_0000 | 32'(k);
      @(negedge i_clk);
    end
    slv_o_valid = 1'b0;
    check("cfg0_pre_commit", entry(0), 32'h0);
    bus_write(8'd8, 32'h2);
    check("commit_done_early", 32'(commit_done), 32'd0);
    check("cfg7_pre_commit", entry(7), 32'h0);
    @(negedge i_clk);
    for (int k = 0; k < NT; k++) check($sformatf("cfg%0d_commit", k), entry(k), 32'hA000_0000 | 32'(k));
    check("commit_done_pulse", 32'(commit_done), 32'd1);
    @(negedge i_clk);
    check("commit_done_single", 32'(commit_done), 32'd0);
    bus_read(8'd9, 32'h0);
    bus_read(8'd8, 32'h0);
    bus_read(8'd2, 32'hA000_0002);

    // Commit deferred while the FSM reads; repeated COMMIT absorbed
    reg_rd_en = 1'b1;
    bus_write(8'd1, 32'hCAFE_BABE);
    bus_write(8'd8, 32'h2);
    bus_write(8'd8, 32'h2);
    repeat (2) @(negedge i_clk);
    check("defer_cfg1", entry(1), 32'hA000_0001);
    check("defer_reg_rd_valid", 32'(reg_rd_valid), 32'd1);
    check("defer_no_done", 32'(commit_done), 32'd0);
    bus_read(8'd9, 32'h1);
    check("defer_cfg1_hold", entry(1), 32'hA000_0001);
    reg_rd_en = 1'b0;
    check("defer_cfg1_pre_edge", entry(1), 32'hA000_0001);
    @(negedge i_clk);
    check("defer_cfg1_commit", entry(1), 32'hCAFE_BABE);
    check("defer_done_pulse", 32'(commit_done), 32'd1);
    check("defer_reg_rd_valid_low", 32'(reg_rd_valid), 32'd0);
    repeat (3) @(negedge i_clk);
    check("defer_done_once", 32'(commit_done), 32'd0);
    bus_read(8'd9, 32'h0);

    // Staging write on the commit edge: old value commits, new value stays staged
    reg_rd_en = 1'b1;
    bus_write(8'd3, 32'h0000_3030);
    bus_write(8'd8, 32'h2);
    reg_rd_en = 1'b0;
    bus_write(8'd3, 32'h0000_0033);
    check("edge_cfg3", entry(3), 32'h0000_3030);
    check("edge_done", 32'(commit_done), 32'd1);
    bus_read(8'd3, 32'h0000_0033);
    bus_read(8'd9, 32'h0);

    // Lock and write-error vectors
    for (int i = 0; i < 11; i++) apply_vec(vec_b[i]);

`ifdef GP_TRIG_REGFILE_WSTRB_EN
    bus_write(8'd3, 32'hFFFF_FFFF);
    slv_o_wr_strb = 4'b0101;
    bus_write(8'd3, 32'h1234_5678);
    slv_o_wr_strb = 4'b1111;
    bus_read(8'd3, 32'hFF34_FF78);
    slv_o_wr_strb = 4'b0000;
    bus_write(8'd13, 32'h0);
    slv_o_wr_strb = 4'b1111;
    bus_read(8'd9, 32'h0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
